// File: rtl/arith_pkg.sv
// Shared definitions for the lab arithmetic datapath: FSM state encodings,
// a digit-counter width helper, and the W-divides-N elaboration check.

`ifndef ARITH_PKG_SV
`define ARITH_PKG_SV

// Elaboration guard: a digit-serial unit only makes sense when the digit
// width tiles the operand exactly. Place this inside a module body.
`define ARITH_CHECK_W_DIVIDES_N(N_, W_) \
    if (((N_) % (W_)) != 0) begin : g_bad_digit_width \
        $error("digit width W must divide operand width N"); \
    end

package arith_pkg;

    // FSM state encoding shared by the serial arithmetic units
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of a counter that indexes `digits` digits, never below 1 bit
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

`endif

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the structural adder.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b computed W bits per clock as a + ~b + 1
// through a chain of W full adders. The (N+1)-bit result carries the
// borrow/sign in its MSB.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// where diff stays stable until out_ready is seen. out_ready is ignored
// outside DONE, and in_ready depends on state alone.

module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   diff,
    output logic [1:0]   dbg_state
);

    `ARITH_CHECK_W_DIVIDES_N(N, W)

    localparam int DIGITS = N / W;
    localparam int CW     = cnt_width(DIGITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_ra;
    logic [N-1:0]  r_rb;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_diff;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic          w_release;
    logic [W:0]    w_carry;
    logic [W-1:0]  w_sum;
    logic [N-1:0]  w_diff_shifted;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_run     = (r_state == ST_RUN);
    assign w_last    = w_run && (r_cnt == LAST_CNT);
    assign w_release = (r_state == ST_DONE) && out_ready;

    // Ripple chain across the low digit of the shift registers
    assign w_carry[0] = r_carry;

    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        full_adder u_fa (
            .a    (r_ra[gi]),
            .b    (r_rb[gi]),
            .cin  (w_carry[gi]),
            .s    (w_sum[gi]),
            .cout (w_carry[gi+1])
        );
    end

    // New digit enters at the MSB end; oldest digit drifts toward bit 0
    assign w_diff_shifted = N'({w_sum, r_diff[N-1:0]} >> W);

    // Control FSM: IDLE -> RUN on accept, RUN -> DONE on last digit,
    // DONE -> IDLE once the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid)  r_state <= ST_RUN;
                ST_RUN:  if (w_last)    r_state <= ST_DONE;
                ST_DONE: if (out_ready) r_state <= ST_IDLE;
                default:                r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand shift registers: capture a and ~b at accept, consume a digit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra <= '0;
            r_rb <= '0;
        end else if (w_accept) begin
            r_ra <= a;
            r_rb <= ~b;
        end else if (w_run) begin
            r_ra <= r_ra >> W;
            r_rb <= r_rb >> W;
        end
    end

    // Carry between digits (starts at 1 to complete the two's complement) and digit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_carry <= w_carry[W];
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result register: collect sum digits during RUN, borrow bit on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
        end else if (w_run) begin
            r_diff[N-1:0] <= w_diff_shifted;
            if (w_last) begin
                r_diff[N] <= ~w_carry[W];
            end
        end
    end

    // Output valid flop: set with the last digit, cleared when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=32, W=4): hand-computed vectors,
// backpressure, operand isolation and mid-operation reset.

module tb_serial_subtractor;

    localparam int N = 32;
    localparam int W = 4;
    localparam int LAT = N / W;
    localparam int BUDGET = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   diff;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_fail;
    logic [N:0] exp_q[$];

    serial_subtractor #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Submit one operation and collect its result. hold > 0 withholds
    // out_ready for that many cycles after out_valid; scramble wiggles a/b
    // during RUN.
    task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                          input logic [N:0] exp_diff, input int hold, input bit scramble,
                          input string tag);
        int edges;
        logic [N:0] held;
        logic [N:0] want;
        exp_q.push_back(exp_diff);
        @(negedge clk);
        out_ready = (hold == 0);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_in_ready_run"}, in_ready, 0);
        edges = 0;
        while (!out_valid && edges < BUDGET) begin
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, LAT);
        want = exp_q.pop_front();
        check({tag, "_diff"}, diff, want);
        held = diff;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bp_valid"}, out_valid, 1);
            check({tag, "_bp_diff"}, diff, held);
            check({tag, "_bp_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_released_valid"}, out_valid, 0);
        check({tag, "_released_in_ready"}, in_ready, 1);
        check({tag, "_released_diff"}, diff, held);
    endtask

    initial begin
        int spurious;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_state", dbg_state, 0);
        rst_n = 1'b1;

        // Directed vectors
        run_op(32'd1000,       32'd1000,       33'h0_0000_0000, 0, 1'b0, "equal");
        run_op(32'd3000,       32'd1000,       33'd2000,        0, 1'b0, "positive");
        run_op(32'd1000,       32'd3000,       33'h1_FFFF_F830, 0, 1'b0, "negative");
        run_op(32'h0000_0000,  32'hFFFF_FFFF,  33'h1_0000_0001, 0, 1'b0, "zero_minus_max");
        run_op(32'hFFFF_FFFF,  32'h0000_0000,  33'h0_FFFF_FFFF, 0, 1'b0, "max_minus_zero");
        run_op(32'd5,          32'd6,          33'h1_FFFF_FFFF, 0, 1'b0, "minus_one");
        run_op(32'h1234_5678,  32'h0000_5678,  33'h0_1234_0000, 0, 1'b0, "mixed_digits");

        // Backpressure, then operand isolation
        run_op(32'hDEAD_BEEF,  32'h0000_BEEF,  33'h0_DEAD_0000, 5, 1'b0, "backpressure");
        run_op(32'h8000_0000,  32'h0000_0001,  33'h0_7FFF_FFFF, 0, 1'b1, "isolation");

        // Reset at RUN cycle 3 discards the partial result
        @(negedge clk);
        a = 32'd7000;
        b = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset_state", dbg_state, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset_in_ready", in_ready, 1);
        check("midrun_reset_out_valid", out_valid, 0);
        check("midrun_reset_diff", diff, 0);
        check("midrun_reset_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("no_stale_result", spurious, 0);
        run_op(32'd2000, 32'd1000, 33'd1000, 0, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something stalls outside the bounded loops
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle digit-serial subtractor: the inverse-direction companion of the structural adder. Accepts two unsigned N-bit operands on a valid/ready input handshake and computes `a - b` W bits per clock through a chain of W full adders, with `b` inverted and carry-in set to 1. It presents an (N+1)-bit two's-complement difference on a valid/ready output handshake. It sits in the lab arithmetic datapath wherever area matters more than latency.

## Interface
- `N`, default 32: operand width.
- `W`, default 4: bits processed per cycle. W must divide N; otherwise elaboration fails.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: operands are valid.
- `in_ready`, output, 1: block accepts operands.
- `a`, input, N: minuend, unsigned.
- `b`, input, N: subtrahend, unsigned.
- `out_valid`, output, 1: `diff` is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `diff`, output, N+1: `{1'b0,a} - {1'b0,b}` mod 2^(N+1). `diff[N]` is the borrow/sign bit.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1: latch `a` into shift register `ra`, `~b` into `rb`. Set carry=1, digit counter `cnt`=0, go to RUN.
- **RUN**
  - `in_ready`=0, `out_valid`=0.
  - Each cycle: add `ra[W-1:0] + rb[W-1:0] + carry` through W chained full adders.
  - Shift the W sum bits into the result register from the MSB end.
  - Shift `ra`/`rb` right by W and store the carry-out. `cnt` increments.
  - When `cnt`==N/W-1, that cycle's edge completes the last digit. At that edge:
    - `diff[N-1:0]` becomes final.
    - `diff[N]` = ~(final carry-out).
    - State goes to DONE.
- **DONE**
  - `out_valid`=1, `diff` is held stable.
  - When `out_ready`=1, go to IDLE. `diff` keeps its value until the next result is loaded.
- `in_ready` is high only in IDLE. A new operation cannot be accepted in the same cycle as the output handshake.
- Operands are sampled only at the accept edge. Changes to `a`/`b` afterwards have no effect.
- Reset (any state, including mid-RUN):
  - State goes to IDLE immediately, asynchronously.
  - `in_ready`=1, `out_valid`=0.
  - `diff`, `ra`, `rb`, `cnt`, carry are all 0.
  - A partial result is discarded and never emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `diff`=0.
- Latency: `out_valid` rises N/W rising edges after the accepting edge. For N=32, W=4 this is 8 cycles.
- Throughput: one result per N/W+2 cycles minimum, when `out_ready` is held high.
- `out_valid`/`diff` are registered outputs, with no combinational path from inputs.
- `in_ready` is decoded from state only, with no path from `in_valid`.
- Backpressure: DONE persists indefinitely while `out_ready`=0.
- `out_ready` is ignored outside DONE.

## Structure
- Shared package `arith_pkg`:
  - FSM state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The W-divides-N check macro.
- Sub-module `full_adder` (a, b, cin → s, cout), instantiated W times in a generate loop. This is the same cell used by the structural adder.
- `cnt` width is $clog2(N/W), with a minimum of 1.

## Test plan
- Equal operands: a=1000, b=1000, `out_ready`=1 → after 8 cycles `out_valid`=1, `diff`=33'h0_0000_0000, then IDLE next cycle.
- Positive result: a=3000, b=1000 → `diff`=33'd2000, `diff[32]`=0.
- Negative result: a=1000, b=3000 → `diff`=33'h1_FFFF_F830.
- Extreme operands:
  - a=0, b=32'hFFFF_FFFF → `diff`=33'h1_0000_0001.
  - a=32'hFFFF_FFFF, b=0 → `diff`=33'h0_FFFF_FFFF.
- Backpressure and operand isolation:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` → `diff` and `out_valid` stay stable and `in_ready` stays 0.
  - Raise `out_ready` → IDLE on the next edge.
  - Toggle `a`/`b` during RUN → result unaffected.
- Reset mid-operation:
  - Assert `rst_n`=0 at RUN cycle 3 → immediately `in_ready`=1, `out_valid`=0, `diff`=0.
  - Release reset, then submit a=2000, b=1000 → `diff`=1000 after 8 cycles, with no stale result emitted.
